// File: rtl/data_mem_pkg.sv
// Package for the data memory with hardware stack.
// Holds the op encoding shared by the memory wrapper and anything that drives it.
package data_mem_pkg;

    typedef enum logic [2:0] {
        OP_NOP   = 3'd0,
        OP_LOAD  = 3'd1,
        OP_STORE = 3'd2,
        OP_PUSH  = 3'd3,
        OP_POP   = 3'd4,
        OP_PEEK  = 3'd5
    } mem_op_t;

endpackage

// File: rtl/mem_core.sv
// WIDTH x DEPTH storage array.
// Ports:
//   clk    rising-edge clock
//   we     write enable, wdata lands in mem[waddr] on the next rising edge
//   waddr  write word address
//   wdata  write data
//   raddr  read word address
//   rdata  combinational read data, mem[raddr]
// The array has no reset, so its contents survive a reset of the wrapper.
module mem_core #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 256,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/data_mem_stack.sv
// Data memory with a hardware stack in its top STACK_DEPTH words.
// One op per cycle (NOP/LOAD/STORE/PUSH/POP/PEEK) on a single op port;
// results are registered and appear the cycle after the op is sampled.
// Ports:
//   clk         rising-edge clock
//   resetN      asynchronous active-low reset
//   op          operation code (mem_op_t), codes 6 and 7 are rejected
//   addr        word address for LOAD/STORE
//   dataIn      write data for STORE/PUSH
//   dataOut     registered read data, holds between reads
//   valid       one-cycle pulse: dataOut was refreshed by the previous op
//   stackCount  words currently on the stack
//   full/empty  stack status, combinational from stackCount
//   error       one-cycle pulse: previous op was rejected
//   fault       sticky OR of error until reset
// Handshake: there is no backpressure. valid is a pure qualifier; a consumer
// must take dataOut in the cycle valid is high, it is never held for it.
module data_mem_stack
    import data_mem_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int DEPTH       = 256,
    parameter int STACK_DEPTH = 16
) (
    input  logic                             clk,
    input  logic                             resetN,
    input  logic [2:0]                       op,
    input  logic [$clog2(DEPTH)-1:0]         addr,
    input  logic [WIDTH-1:0]                 dataIn,
    output logic [WIDTH-1:0]                 dataOut,
    output logic                             valid,
    output logic [$clog2(STACK_DEPTH+1)-1:0] stackCount,
    output logic                             full,
    output logic                             empty,
    output logic                             error,
    output logic                             fault
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int CNT_W  = $clog2(STACK_DEPTH + 1);

    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [WIDTH-1:0]  mem_rdata;

    logic              do_read;
    logic              err_next;
    logic [CNT_W-1:0]  cnt_next;
    logic              addr_ok;
    logic [ADDR_W:0]   push_wide;
    logic [ADDR_W:0]   pop_wide;

    // One op per cycle, so a single address serves both the read and write side.
    mem_core #(
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_core (
        .clk   (clk),
        .we    (mem_we),
        .waddr (mem_addr),
        .wdata (dataIn),
        .raddr (mem_addr),
        .rdata (mem_rdata)
    );

    assign full  = (stackCount == CNT_W'(STACK_DEPTH));
    assign empty = (stackCount == '0);

    // Only reachable when DEPTH is not a power of two.
    assign addr_ok = ({1'b0, addr} < (ADDR_W+1)'(DEPTH));

    // Stack grows downward from DEPTH-1. Computed one bit wider than the
    // address; the result always fits in ADDR_W because STACK_DEPTH <= DEPTH
    // and each address is only used when the count keeps it in range.
    assign push_wide = (ADDR_W+1)'(DEPTH - 1) - (ADDR_W+1)'(stackCount);
    assign pop_wide  = (ADDR_W+1)'(DEPTH)     - (ADDR_W+1)'(stackCount);

    always_comb begin
        mem_we   = 1'b0;
        mem_addr = addr;
        do_read  = 1'b0;
        err_next = 1'b0;
        cnt_next = stackCount;
        case (mem_op_t'(op))
            OP_NOP: begin
            end
            OP_LOAD: begin
                if (addr_ok) do_read  = 1'b1;
                else         err_next = 1'b1;
            end
            OP_STORE: begin
                if (addr_ok) mem_we   = 1'b1;
                else         err_next = 1'b1;
            end
            OP_PUSH: begin
                if (!full) begin
                    mem_we   = 1'b1;
                    mem_addr = push_wide[ADDR_W-1:0];
                    cnt_next = stackCount + CNT_W'(1);
                end else begin
                    err_next = 1'b1;
                end
            end
            OP_POP, OP_PEEK: begin
                if (!empty) begin
                    do_read  = 1'b1;
                    mem_addr = pop_wide[ADDR_W-1:0];
                    if (mem_op_t'(op) == OP_POP) cnt_next = stackCount - CNT_W'(1);
                end else begin
                    err_next = 1'b1;
                end
            end
            default: begin
                err_next = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            dataOut    <= '0;
            valid      <= 1'b0;
            error      <= 1'b0;
            fault      <= 1'b0;
            stackCount <= '0;
        end else begin
            valid      <= do_read;
            error      <= err_next;
            fault      <= fault | err_next;
            stackCount <= cnt_next;
            if (do_read) dataOut <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_data_mem_stack.sv
module tb_data_mem_stack;
  import data_mem_pkg::*;

  typedef struct packed {
    logic       v;
    logic       e;
    logic       f;
    logic [4:0] c;
  } exp_t;

  logic       clk;
  logic       resetN;
  logic [2:0] op;
  logic [7:0] addr;
  logic [7:0] dataIn;
  logic [7:0] dataOut;
  logic       valid;
  logic [4:0] stackCount;
  logic       full;
  logic       empty;
  logic       error;
  logic       fault;

  logic [7:0] exp_q[$];
  exp_t       flag_q[$];
  logic [7:0] last_data;
  int         n_cmp;
  int         n_bad;

  data_mem_stack #(
    .WIDTH       (8),
    .DEPTH       (256),
    .STACK_DEPTH (16)
  ) dut (
    .clk        (clk),
    .resetN     (resetN),
    .op         (op),
    .addr       (addr),
    .dataIn     (dataIn),
    .dataOut    (dataOut),
    .valid      (valid),
    .stackCount (stackCount),
    .full       (full),
    .empty      (empty),
    .error      (error),
    .fault      (fault)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // driver: issue one op, then queue the response it must produce next cycle
  task automatic do_op(input logic [2:0] o, input logic [7:0] a, input logic [7:0] d,
                       input logic xv, input logic [7:0] xd, input logic xe,
                       input logic [4:0] xc, input logic xf);
    exp_t e;
    op     = o;
    addr   = a;
    dataIn = d;
    @(posedge clk);
    e.v = xv; e.e = xe; e.f = xf; e.c = xc;
    flag_q.push_back(e);
    if (xv) exp_q.push_back(xd);
    #1;
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    exp_t e;
    logic [7:0] d;
    if (resetN && flag_q.size() > 0) begin
      e = flag_q.pop_front();
      check("valid", {31'd0, valid}, {31'd0, e.v});
      check("error", {31'd0, error}, {31'd0, e.e});
      check("fault", {31'd0, fault}, {31'd0, e.f});
      check("stackCount", {27'd0, stackCount}, {27'd0, e.c});
      check("full", {31'd0, full}, {31'd0, (e.c == 5'd16)});
      check("empty", {31'd0, empty}, {31'd0, (e.c == 5'd0)});
      if (e.v) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL data_queue: actual=empty required=entry at %0t", $time);
        end else begin
          d = exp_q.pop_front();
          check("dataOut", {24'd0, dataOut}, {24'd0, d});
          last_data = d;
        end
      end else begin
        check("dataOut_hold", {24'd0, dataOut}, {24'd0, last_data});
      end
    end
  end

  initial begin
    n_cmp = 0; n_bad = 0; last_data = 8'h00;
    op = 3'd0; addr = 8'h00; dataIn = 8'h00;
    resetN = 1'b0;
    #23;
    // reset state
    check("rst_dataOut", {24'd0, dataOut}, 32'h0);
    check("rst_valid", {31'd0, valid}, 32'h0);
    check("rst_error", {31'd0, error}, 32'h0);
    check("rst_fault", {31'd0, fault}, 32'h0);
    check("rst_count", {27'd0, stackCount}, 32'h0);
    check("rst_empty", {31'd0, empty}, 32'h1);
    check("rst_full", {31'd0, full}, 32'h0);
    @(negedge clk);
    resetN = 1'b1;
    @(posedge clk); #1;

    // 1: store/load
    do_op(OP_STORE, 8'h10, 8'hA5, 0, 8'h00, 0, 5'd0, 0);
    do_op(OP_LOAD,  8'h10, 8'h00, 1, 8'hA5, 0, 5'd0, 0);
    do_op(OP_NOP,   8'h00, 8'h00, 0, 8'h00, 0, 5'd0, 0);

    // 2: push three, pop three
    do_op(OP_PUSH, 8'h00, 8'h11, 0, 8'h00, 0, 5'd1, 0);
    do_op(OP_PUSH, 8'h00, 8'h22, 0, 8'h00, 0, 5'd2, 0);
    do_op(OP_PUSH, 8'h00, 8'h33, 0, 8'h00, 0, 5'd3, 0);
    do_op(OP_POP,  8'h00, 8'h00, 1, 8'h33, 0, 5'd2, 0);
    do_op(OP_POP,  8'h00, 8'h00, 1, 8'h22, 0, 5'd1, 0);
    do_op(OP_POP,  8'h00, 8'h00, 1, 8'h11, 0, 5'd0, 0);
    do_op(OP_LOAD, 8'hFF, 8'h00, 1, 8'h11, 0, 5'd0, 0);

    // 3: fill stack, overflow
    do_op(OP_STORE, 8'hEF, 8'h5A, 0, 8'h00, 0, 5'd0, 0);
    do_op(OP_STORE, 8'hEE, 8'h3C, 0, 8'h00, 0, 5'd0, 0);
    for (int i = 0; i < 16; i++)
      do_op(OP_PUSH, 8'h00, 8'h80 + 8'(i), 0, 8'h00, 0, 5'(i + 1), 0);
    do_op(OP_PUSH, 8'h00, 8'h99, 0, 8'h00, 1, 5'd16, 1);
    do_op(OP_NOP,  8'h00, 8'h00, 0, 8'h00, 0, 5'd16, 1);
    do_op(OP_LOAD, 8'hEF, 8'h00, 1, 8'h5A, 0, 5'd16, 1);
    do_op(OP_LOAD, 8'hEE, 8'h00, 1, 8'h3C, 0, 5'd16, 1);
    do_op(OP_LOAD, 8'hF0, 8'h00, 1, 8'h8F, 0, 5'd16, 1);
    for (int i = 15; i >= 0; i--)
      do_op(OP_POP, 8'h00, 8'h00, 1, 8'h80 + 8'(i), 0, 5'(i), 1);

    // 4: pop on empty, dataOut holds 0x80
    do_op(OP_POP, 8'h00, 8'h00, 0, 8'h00, 1, 5'd0, 1);
    do_op(OP_NOP, 8'h00, 8'h00, 0, 8'h00, 0, 5'd0, 1);
    do_op(OP_NOP, 8'h00, 8'h00, 0, 8'h00, 0, 5'd0, 1);

    // 5: peek, illegal ops
    do_op(OP_PUSH, 8'h00, 8'h7E, 0, 8'h00, 0, 5'd1, 1);
    do_op(OP_PEEK, 8'h00, 8'h00, 1, 8'h7E, 0, 5'd1, 1);
    do_op(OP_PEEK, 8'h00, 8'h00, 1, 8'h7E, 0, 5'd1, 1);
    do_op(3'd6,    8'h10, 8'h55, 0, 8'h00, 1, 5'd1, 1);
    do_op(3'd7,    8'h10, 8'h55, 0, 8'h00, 1, 5'd1, 1);
    do_op(OP_PEEK, 8'h00, 8'h00, 1, 8'h7E, 0, 5'd1, 1);

    // 6: count to 5, then asynchronous reset mid-cycle
    for (int i = 0; i < 4; i++)
      do_op(OP_PUSH, 8'h00, 8'hC0 + 8'(i), 0, 8'h00, 0, 5'(i + 2), 1);
    op = OP_NOP;
    @(negedge clk); #1;
    check("pre_rst_count", {27'd0, stackCount}, 32'd5);
    #2 resetN = 1'b0;
    #1;
    check("async_dataOut", {24'd0, dataOut}, 32'h0);
    check("async_fault", {31'd0, fault}, 32'h0);
    check("async_count", {27'd0, stackCount}, 32'h0);
    check("async_empty", {31'd0, empty}, 32'h1);
    last_data = 8'h00;
    @(negedge clk);
    resetN = 1'b1;
    @(posedge clk); #1;
    do_op(OP_LOAD, 8'h10, 8'h00, 1, 8'hA5, 0, 5'd0, 0);
    do_op(OP_NOP,  8'h00, 8'h00, 0, 8'h00, 0, 5'd0, 0);

    @(negedge clk); #1;
    check("flag_q_drained", flag_q.size(), 32'd0);
    check("exp_q_drained", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
